// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reset sequencer: sequencer states, retry width, counter sizing.
// Pure definitions; no latency, no flow control.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILISE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int RETRY_W = 4;

  // One spare bit above the largest cycle limit keeps terminal compares free of wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchroniser for a single asynchronous level, reset to 0.
// Latency: 2 clk edges; no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL bring-up sequencer: timed reset pulse, lock wait with retries, stability qualification, loss-of-lock recovery.
// Latency: outputs registered from next state; ready rises LOCK_STABLE_CYCLES+2 edges after lock is sampled; no backpressure.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               restart_req,
  output logic               pll_rst,
  output logic               ready,
  output logic               fault,
  output logic               lost_lock,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  pll_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost_nxt;
  logic               attempt_fail;
  logic               locked_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt    = state;
    retry_nxt    = retry_count;
    lost_nxt     = lost_lock;
    attempt_fail = 1'b0;

    // A restart request overrides every other transition, including a lock drop in RUN.
    if (restart_req) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
      lost_nxt  = 1'b0;
    end else begin
      case (state)
        RESET_PLL: if (cnt == PULSE_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s)                   state_nxt    = STABILISE;
          else if (cnt == TIMEOUT_LAST)   attempt_fail = 1'b1;
        end
        STABILISE: begin
          if (!locked_s) begin
            attempt_fail = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            lost_nxt  = 1'b1;
            state_nxt = RESET_PLL;
          end
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RESET_PLL;
      endcase

      if (attempt_fail) begin
        if (retry_count == RETRY_LIMIT) begin
          state_nxt = FAULT;
        end else begin
          retry_nxt = retry_count + RETRY_W'(1);
          state_nxt = RESET_PLL;
        end
      end
    end

    // The counter only runs in the timed states and restarts on every state change.
    if (restart_req || (state_nxt != state) || (state == RUN) || (state == FAULT)) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      lost_lock   <= 1'b0;
      pll_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      lost_lock   <= lost_nxt;
      pll_rst     <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      ready       <= (state_nxt == RUN);
      fault       <= (state_nxt == FAULT);
    end
  end

endmodule
